adc_scan_fsm: RTL and testbench

Parametrised successor of the single-channel ADC read FSM. Round-robin scans up to 4 single-ended inputs of an ADS1115-class I2C ADC in single-shot mode. Drives the existing I2C master transaction interface and publishes per-channel 16-bit results with a valid strobe. Sits between the I2C master and the PID wall-follower distance logic.

---
 rtl/adc_scan_pkg.sv | 28 ++
 rtl/adc_scan_fsm_if.sv | 43 ++++
 rtl/adc_next_channel.sv | 28 ++
 rtl/adc_scan_fsm.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_adc_scan_fsm.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADS1115-class round-robin scanner.
// Contents: FSM state enum, ADS1115 register pointers and config constants,
// and cfg_msb(), which builds the config-register MSB for a single-ended channel.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StConvWait,
        StSelectData,
        StRead,
        StTxnWait,
        StNextCh,
        StScanDelay
    } adc_state_e;

    localparam logic [7:0] PTR_CONV   = 8'h00;
    localparam logic [7:0] PTR_CONFIG = 8'h01;
    localparam logic [7:0] CFG_LSB    = 8'h83;
    localparam logic [2:0] CFG_PGA    = 3'b001;

    // OS=1 starts a single-shot conversion, MUX=1xx selects AINx vs GND,
    // PGA=+/-4.096 V, MODE=1 is single-shot.
    function automatic logic [7:0] cfg_msb(input logic [1:0] ch);
        return {1'b1, 1'b1, ch, CFG_PGA, 1'b1};
    endfunction

endpackage

// File: rtl/adc_scan_fsm_if.sv
// Transaction interface between the ADC scanner (master) and the I2C master
// engine (slave).
//   i2c_transaction_start      : one-cycle start pulse
//   i2c_transaction_rd_nwr     : 1 = read, 0 = write
//   i2c_transaction_slave_addr : 7-bit target address
//   i2c_master_din             : write bytes, [0] sent first
//   i2c_transaction_bytes_num  : byte count of the transaction
//   i2c_transaction_done       : one-cycle pulse at transaction end
//   i2c_master_dout            : read bytes, [0] received first
interface adc_scan_fsm_if #(
    parameter int unsigned MAX_BYTES_PER_TRANSACTION = 3
);
    localparam int unsigned BYTES_W = $clog2(MAX_BYTES_PER_TRANSACTION + 1);

    logic                                      i2c_transaction_start;
    logic                                      i2c_transaction_rd_nwr;
    logic [6:0]                                i2c_transaction_slave_addr;
    logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0] i2c_master_din;
    logic [BYTES_W-1:0]                        i2c_transaction_bytes_num;
    logic                                      i2c_transaction_done;
    logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0] i2c_master_dout;

    modport master (
        output i2c_transaction_start,
        output i2c_transaction_rd_nwr,
        output i2c_transaction_slave_addr,
        output i2c_master_din,
        output i2c_transaction_bytes_num,
        input  i2c_transaction_done,
        input  i2c_master_dout
    );

    modport slave (
        input  i2c_transaction_start,
        input  i2c_transaction_rd_nwr,
        input  i2c_transaction_slave_addr,
        input  i2c_master_din,
        input  i2c_transaction_bytes_num,
        output i2c_transaction_done,
        output i2c_master_dout
    );

endinterface

// File: rtl/adc_next_channel.sv
// Combinational priority finder: lowest set bit of mask_i strictly above cur_ch_i.
// cur_ch_i is signed so that -1 selects the lowest set bit overall.
//   mask_i    : channel enable mask
//   cur_ch_i  : current channel (signed, -1 = none yet)
//   next_ch_o : next channel to scan
//   found_o   : a candidate exists
module adc_next_channel #(
    parameter int unsigned NUM_CHANNELS = 4
) (
    input  logic [NUM_CHANNELS-1:0] mask_i,
    input  logic signed [2:0]       cur_ch_i,
    output logic [1:0]              next_ch_o,
    output logic                    found_o
);

    // Walk downward so the lowest qualifying channel is the last one written.
    always_comb begin
        next_ch_o = '0;
        found_o   = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_ch_i))) begin
                found_o   = 1'b1;
                next_ch_o = 2'(i);
            end
        end
    end

endmodule

// File: rtl/adc_scan_fsm.sv
// Round-robin single-shot scanner for up to four single-ended inputs of an
// ADS1115-class ADC. Per channel: write config (starts conversion), wait the
// conversion time, select the conversion register, read two bytes.
// Optional feature macro: ADC_TIMEOUT_EN adds TIMEOUT_CYCLES and timeout_err.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : scanning runs while high (sampled in idle / scan delay)
//   channel_mask   : channels to scan, latched at scan start
//   i2c            : master side of the I2C transaction interface
//   sample_valid   : one-cycle pulse with a new result
//   sample_channel : channel of sample_data
//   sample_data    : signed conversion result {MSB, LSB}
//   channel_data   : last result per channel, held
//   scan_done      : one-cycle pulse after the last channel of a scan
//   timeout_err    : sticky, a transaction exceeded TIMEOUT_CYCLES (macro only)
module adc_scan_fsm
    import adc_scan_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS              = 4,
    parameter int unsigned MAX_BYTES_PER_TRANSACTION = 3,
    parameter logic [6:0]  SLAVE_ADDR                = 7'h48,
    parameter int unsigned CONV_WAIT_CYCLES          = 1_250_000,
    parameter int unsigned SCAN_DELAY_CYCLES         = 6_250_000
`ifdef ADC_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES            = 1_000_000
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_CHANNELS-1:0]      channel_mask,
    adc_scan_fsm_if.master               i2c,
    output logic                         sample_valid,
    output logic [1:0]                   sample_channel,
    output logic [15:0]                  sample_data,
    output logic [NUM_CHANNELS-1:0][15:0] channel_data,
    output logic                         scan_done
`ifdef ADC_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);

    localparam int unsigned BYTES_W = $clog2(MAX_BYTES_PER_TRANSACTION + 1);

    adc_state_e state_q, state_d;
    adc_state_e ret_q, ret_d;
    logic [1:0]              ch_q, ch_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [31:0]             cnt_q, cnt_d;

    logic                                      start_q, start_d;
    logic                                      rd_nwr_q, rd_nwr_d;
    logic [BYTES_W-1:0]                        bytes_q, bytes_d;
    logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0] din_q, din_d;
    logic                                      sample_valid_q, sample_valid_d;
    logic [1:0]                                sample_channel_q, sample_channel_d;
    logic [15:0]                               sample_data_q, sample_data_d;
    logic [NUM_CHANNELS-1:0][15:0]             channel_data_q, channel_data_d;
    logic                                      scan_done_q, scan_done_d;
    logic                                      timeout_err_q, timeout_err_d;

    logic [1:0] first_ch, next_ch;
    logic       first_found, next_found;
    logic       txn_done, txn_timeout;

    // Only the first two read bytes carry the conversion result.
    logic unused_dout;
    assign unused_dout = ^i2c.i2c_master_dout[MAX_BYTES_PER_TRANSACTION-1:2];

    adc_next_channel #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_first (
        .mask_i   (channel_mask),
        .cur_ch_i (3'sb111),
        .next_ch_o(first_ch),
        .found_o  (first_found)
    );

    adc_next_channel #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_next (
        .mask_i   (mask_q),
        .cur_ch_i (signed'({1'b0, ch_q})),
        .next_ch_o(next_ch),
        .found_o  (next_found)
    );

    assign txn_done = (state_q == StTxnWait) && i2c.i2c_transaction_done;

`ifdef ADC_TIMEOUT_EN
    assign txn_timeout = (state_q == StTxnWait) && !i2c.i2c_transaction_done &&
                         (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign txn_timeout = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            ret_q            <= StIdle;
            ch_q             <= '0;
            mask_q           <= '0;
            cnt_q            <= '0;
            start_q          <= 1'b0;
            rd_nwr_q         <= 1'b0;
            bytes_q          <= '0;
            din_q            <= '0;
            sample_valid_q   <= 1'b0;
            sample_channel_q <= '0;
            sample_data_q    <= '0;
            channel_data_q   <= '0;
            scan_done_q      <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            ret_q            <= ret_d;
            ch_q             <= ch_d;
            mask_q           <= mask_d;
            cnt_q            <= cnt_d;
            start_q          <= start_d;
            rd_nwr_q         <= rd_nwr_d;
            bytes_q          <= bytes_d;
            din_q            <= din_d;
            sample_valid_q   <= sample_valid_d;
            sample_channel_q <= sample_channel_d;
            sample_data_q    <= sample_data_d;
            channel_data_q   <= channel_data_d;
            scan_done_q      <= scan_done_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (enable && first_found) begin
                    mask_d  = channel_mask;
                    ch_d    = first_ch;
                    state_d = StConfig;
                end
            end
            StConfig: begin
                ret_d   = StConvWait;
                state_d = StTxnWait;
            end
            StConvWait: begin
                if (cnt_q == 32'(CONV_WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StSelectData;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StSelectData: begin
                ret_d   = StRead;
                state_d = StTxnWait;
            end
            StRead: begin
                ret_d   = StNextCh;
                state_d = StTxnWait;
            end
            StTxnWait: begin
                if (txn_done) begin
                    cnt_d   = '0;
                    state_d = ret_q;
                end else if (txn_timeout) begin
                    // Abandon the channel; its result is left untouched.
                    cnt_d   = '0;
                    state_d = StNextCh;
                end else begin
`ifdef ADC_TIMEOUT_EN
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
            StNextCh: begin
                if (next_found) begin
                    ch_d    = next_ch;
                    state_d = StConfig;
                end else begin
                    state_d = StScanDelay;
                end
            end
            StScanDelay: begin
                if (cnt_q == 32'(SCAN_DELAY_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (enable && first_found) begin
                        mask_d  = channel_mask;
                        ch_d    = first_ch;
                        state_d = StConfig;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic. Transaction fields are loaded together with the start pulse
    // and then held until the next transaction.
    always_comb begin
        start_d          = 1'b0;
        rd_nwr_d         = rd_nwr_q;
        bytes_d          = bytes_q;
        din_d            = din_q;
        sample_valid_d   = 1'b0;
        sample_channel_d = sample_channel_q;
        sample_data_d    = sample_data_q;
        channel_data_d   = channel_data_q;
        scan_done_d      = 1'b0;
        timeout_err_d    = timeout_err_q;
        case (state_q)
            StConfig: begin
                start_d  = 1'b1;
                rd_nwr_d = 1'b0;
                bytes_d  = BYTES_W'(3);
                din_d    = '0;
                din_d[0] = PTR_CONFIG;
                din_d[1] = cfg_msb(ch_q);
                din_d[2] = CFG_LSB;
            end
            StSelectData: begin
                start_d  = 1'b1;
                rd_nwr_d = 1'b0;
                bytes_d  = BYTES_W'(1);
                din_d    = '0;
                din_d[0] = PTR_CONV;
            end
            StRead: begin
                start_d  = 1'b1;
                rd_nwr_d = 1'b1;
                bytes_d  = BYTES_W'(2);
            end
            StTxnWait: begin
                // A completed read is the only transaction that returns to StNextCh.
                if (txn_done && (ret_q == StNextCh)) begin
                    sample_valid_d       = 1'b1;
                    sample_channel_d     = ch_q;
                    sample_data_d        = {i2c.i2c_master_dout[0], i2c.i2c_master_dout[1]};
                    channel_data_d[ch_q] = {i2c.i2c_master_dout[0], i2c.i2c_master_dout[1]};
                end
                if (txn_timeout) begin
                    timeout_err_d = 1'b1;
                end
            end
            StNextCh: begin
                if (!next_found) begin
                    scan_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign i2c.i2c_transaction_start      = start_q;
    assign i2c.i2c_transaction_rd_nwr     = rd_nwr_q;
    assign i2c.i2c_transaction_slave_addr = SLAVE_ADDR;
    assign i2c.i2c_master_din             = din_q;
    assign i2c.i2c_transaction_bytes_num  = bytes_q;

    assign sample_valid   = sample_valid_q;
    assign sample_channel = sample_channel_q;
    assign sample_data    = sample_data_q;
    assign channel_data   = channel_data_q;
    assign scan_done      = scan_done_q;
`ifdef ADC_TIMEOUT_EN
    assign timeout_err    = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_err_q ^ timeout_err_d;
`endif

endmodule

// File: tb/tb_adc_scan_fsm.sv
// Self-checking bench for adc_scan_fsm: table of single-scan vectors, random
// multi-scan run against a transaction-level model, and hand-written sequences
// for enable drop, reset abort and (with ADC_TIMEOUT_EN) transaction timeout.
module tb_adc_scan_fsm;

    localparam int NCH  = 4;
    localparam int MAXB = 3;
    localparam int CW   = 20;
    localparam int SD   = 40;
`ifdef ADC_TIMEOUT_EN
    localparam int TO   = 100;
`endif

    typedef struct {
        bit         rd;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } txn_t;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] dout;
        int          exp_nsamp;
        int          exp_first_ch;
        int          exp_last_ch;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic [NCH-1:0] channel_mask = '0;
    logic sample_valid;
    logic [1:0] sample_channel;
    logic [15:0] sample_data;
    logic [NCH-1:0][15:0] channel_data;
    logic scan_done;
`ifdef ADC_TIMEOUT_EN
    logic timeout_err;
`endif

    adc_scan_fsm_if #(.MAX_BYTES_PER_TRANSACTION(MAXB)) i2c ();

    adc_scan_fsm #(
        .NUM_CHANNELS             (NCH),
        .MAX_BYTES_PER_TRANSACTION(MAXB),
        .SLAVE_ADDR               (7'h48),
        .CONV_WAIT_CYCLES         (CW),
        .SCAN_DELAY_CYCLES        (SD)
`ifdef ADC_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES           (TO)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .channel_mask  (channel_mask),
        .i2c           (i2c),
        .sample_valid  (sample_valid),
        .sample_channel(sample_channel),
        .sample_data   (sample_data),
        .channel_data  (channel_data),
        .scan_done     (scan_done)
`ifdef ADC_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stub / monitor state
    int          cyc = 0;
    int          stub_cnt = 0;
    bit          stub_hold = 0;
    logic [7:0]  hold_cfg = 8'h00;
    bit          hold_en = 0;
    bit          fixed_en = 1;
    logic [15:0] fixed_data = 16'h0;
    bit          prev_start = 0;
    int          dbl_start = 0;
    int          sd_cnt = 0;
    txn_t        txn_log[$];
    int          start_cyc[$];
    int          done_cyc[$];
    logic [15:0] rd_data_log[$];
    int          samp_ch[$];
    logic [15:0] samp_data[$];
    int          sd_cyc[$];

    // Model output
    txn_t exp_txn[$];
    int   exp_ch[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // I2C slave stub and output monitor, one sampling point per cycle.
    initial begin
        txn_t t;
        logic [15:0] d;
        i2c.i2c_transaction_done = 1'b0;
        i2c.i2c_master_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i2c.i2c_transaction_done = 1'b0;
            if (sample_valid) begin
                samp_ch.push_back(int'(sample_channel));
                samp_data.push_back(sample_data);
            end
            if (scan_done) begin
                sd_cnt++;
                sd_cyc.push_back(cyc);
            end
            if (i2c.i2c_transaction_start && prev_start) dbl_start++;
            prev_start = i2c.i2c_transaction_start;
            if (!rst_n) begin
                stub_cnt = 0;
            end else begin
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0 && !stub_hold) begin
                        i2c.i2c_transaction_done = 1'b1;
                        done_cyc.push_back(cyc);
                    end
                end
                if (i2c.i2c_transaction_start) begin
                    t.rd     = i2c.i2c_transaction_rd_nwr;
                    t.nbytes = int'(i2c.i2c_transaction_bytes_num);
                    t.b0     = i2c.i2c_master_din[0];
                    t.b1     = i2c.i2c_master_din[1];
                    t.b2     = i2c.i2c_master_din[2];
                    txn_log.push_back(t);
                    start_cyc.push_back(cyc);
                    stub_cnt  = 5;
                    stub_hold = hold_en && !t.rd && t.nbytes == 3 && t.b1 == hold_cfg;
                    if (t.rd) begin
                        d = fixed_en ? fixed_data : 16'($urandom);
                        i2c.i2c_master_dout[0] = d[15:8];
                        i2c.i2c_master_dout[1] = d[7:0];
                        rd_data_log.push_back(d);
                    end
                end
            end
        end
    end

    // Transaction-level model: a scan visits set bits in ascending order and
    // issues config write, pointer write, two-byte read for each.
    task automatic model_scan(input logic [3:0] m);
        txn_t t;
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                t.rd = 0; t.nbytes = 3; t.b0 = 8'h01; t.b1 = 8'hC3 + 8'(c * 16); t.b2 = 8'h83;
                exp_txn.push_back(t);
                t.rd = 0; t.nbytes = 1; t.b0 = 8'h00; t.b1 = 8'h00; t.b2 = 8'h00;
                exp_txn.push_back(t);
                t.rd = 1; t.nbytes = 2;
                exp_txn.push_back(t);
                exp_ch.push_back(c);
            end
        end
    endtask

    task automatic check_txns(input string tag);
        int n;
        check($sformatf("%s_txn_count", tag), txn_log.size(), exp_txn.size());
        n = (txn_log.size() < exp_txn.size()) ? txn_log.size() : exp_txn.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_txn%0d_rd", tag, i), txn_log[i].rd, exp_txn[i].rd);
            check($sformatf("%s_txn%0d_nbytes", tag, i), txn_log[i].nbytes, exp_txn[i].nbytes);
            if (!exp_txn[i].rd) check($sformatf("%s_txn%0d_b0", tag, i), txn_log[i].b0, exp_txn[i].b0);
            if (exp_txn[i].nbytes == 3) begin
                check($sformatf("%s_txn%0d_b1", tag, i), txn_log[i].b1, exp_txn[i].b1);
                check($sformatf("%s_txn%0d_b2", tag, i), txn_log[i].b2, exp_txn[i].b2);
            end
        end
    endtask

    task automatic clear_logs();
        txn_log.delete(); start_cyc.delete(); done_cyc.delete(); rd_data_log.delete();
        samp_ch.delete(); samp_data.delete(); sd_cyc.delete();
        exp_txn.delete(); exp_ch.delete();
        sd_cnt = 0; dbl_start = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_scan_done(input string name, input int target, input int budget);
        int n = 0;
        while (sd_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_scan_done_seen", name), sd_cnt >= target, 1);
    endtask

    task automatic wait_txn(input string name, input int target, input int budget);
        int n = 0;
        while (txn_log.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_txn_seen", name), txn_log.size() >= target, 1);
    endtask

    vec_t vecs[5];

    initial begin
        logic [3:0]  masks[4];
        logic [15:0] last_val[NCH];
        int          acc;

        vecs[0] = '{mask: 4'b1111, dout: 16'h1234, exp_nsamp: 4, exp_first_ch: 0, exp_last_ch: 3};
        vecs[1] = '{mask: 4'b0101, dout: 16'hBEEF, exp_nsamp: 2, exp_first_ch: 0, exp_last_ch: 2};
        vecs[2] = '{mask: 4'b1000, dout: 16'h8001, exp_nsamp: 1, exp_first_ch: 3, exp_last_ch: 3};
        vecs[3] = '{mask: 4'b0110, dout: 16'h7FFF, exp_nsamp: 2, exp_first_ch: 1, exp_last_ch: 2};
        vecs[4] = '{mask: 4'b0001, dout: 16'h00FF, exp_nsamp: 1, exp_first_ch: 0, exp_last_ch: 0};

        // Reset values, asserted asynchronously between edges.
        #3 rst_n = 1'b0;
        #1;
        check("rst_start", i2c.i2c_transaction_start, 0);
        check("rst_rd_nwr", i2c.i2c_transaction_rd_nwr, 0);
        check("rst_bytes", 32'(i2c.i2c_transaction_bytes_num), 0);
        check("rst_din", 32'(i2c.i2c_master_din), 0);
        check("rst_slave_addr", 32'(i2c.i2c_transaction_slave_addr), 32'h48);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_data", 32'(sample_data), 0);
        check("rst_sample_channel", 32'(sample_channel), 0);
        check("rst_channel_data", (channel_data == '0), 1);
        check("rst_scan_done", scan_done, 0);
`ifdef ADC_TIMEOUT_EN
        check("rst_timeout_err", timeout_err, 0);
`endif
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;

        // Enabled with an empty mask: nothing happens.
        enable = 1'b1;
        channel_mask = 4'b0000;
        repeat (200) @(negedge clk);
        check("mask0_no_start", txn_log.size(), 0);
        check("mask0_no_scan_done", sd_cnt, 0);
        enable = 1'b0;

        // Table-driven single scans.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            fixed_en = 1;
            fixed_data = vecs[v].dout;
            channel_mask = vecs[v].mask;
            enable = 1'b1;
            wait_scan_done($sformatf("vec%0d", v), 1, 2000);
            enable = 1'b0;
            repeat (SD + 20) @(negedge clk);
            model_scan(vecs[v].mask);
            check_txns($sformatf("vec%0d", v));
            check($sformatf("vec%0d_nsamp", v), samp_ch.size(), vecs[v].exp_nsamp);
            if (samp_ch.size() > 0) begin
                check($sformatf("vec%0d_first_ch", v), samp_ch[0], vecs[v].exp_first_ch);
                check($sformatf("vec%0d_last_ch", v), samp_ch[samp_ch.size() - 1],
                      vecs[v].exp_last_ch);
            end
            for (int i = 0; i < samp_ch.size() && i < exp_ch.size(); i++) begin
                check($sformatf("vec%0d_samp%0d_ch", v, i), samp_ch[i], exp_ch[i]);
                check($sformatf("vec%0d_samp%0d_data", v, i), samp_data[i], vecs[v].dout);
            end
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("vec%0d_chdata%0d", v, c), channel_data[c],
                      vecs[v].mask[c] ? vecs[v].dout : 16'h0);
            end
            check($sformatf("vec%0d_scan_done_cnt", v), sd_cnt, 1);
            check($sformatf("vec%0d_single_start", v), dbl_start, 0);
        end

        // Random multi-scan run; mask scribbled mid-scan must be ignored.
        for (int round = 0; round < 2; round++) begin
            do_reset();
            fixed_en = 0;
            for (int s = 0; s < 4; s++) masks[s] = 4'($urandom_range(1, 15));
            channel_mask = masks[0];
            enable = 1'b1;
            acc = 0;
            for (int s = 0; s < 4; s++) begin
                wait_txn($sformatf("rnd%0d_scan%0d_start", round, s), acc + 1, 2000);
                channel_mask = 4'($urandom_range(0, 15));
                acc += 3 * $countones(masks[s]);
                wait_scan_done($sformatf("rnd%0d_scan%0d", round, s), s + 1, 3000);
                if (s < 3) channel_mask = masks[s + 1];
                else enable = 1'b0;
            end
            repeat (SD + 20) @(negedge clk);
            for (int s = 0; s < 4; s++) model_scan(masks[s]);
            check_txns($sformatf("rnd%0d", round));
            check($sformatf("rnd%0d_nsamp", round), samp_ch.size(), exp_ch.size());
            for (int c = 0; c < NCH; c++) last_val[c] = 16'h0;
            for (int i = 0; i < samp_ch.size() && i < exp_ch.size() && i < rd_data_log.size(); i++) begin
                check($sformatf("rnd%0d_samp%0d_ch", round, i), samp_ch[i], exp_ch[i]);
                check($sformatf("rnd%0d_samp%0d_data", round, i), samp_data[i], rd_data_log[i]);
                last_val[exp_ch[i]] = rd_data_log[i];
            end
            for (int c = 0; c < NCH; c++)
                check($sformatf("rnd%0d_chdata%0d", round, c), channel_data[c], last_val[c]);
            // Conversion wait after each config write, scan delay between scans.
            for (int i = 0; i + 1 < txn_log.size() && i < done_cyc.size(); i++) begin
                if (txn_log[i].nbytes == 3)
                    check_range($sformatf("rnd%0d_conv_gap%0d", round, i),
                                start_cyc[i + 1] - done_cyc[i], CW, CW + 3);
            end
            acc = 0;
            for (int s = 0; s < 3 && s < sd_cyc.size(); s++) begin
                acc += 3 * $countones(masks[s]);
                if (acc < start_cyc.size())
                    check_range($sformatf("rnd%0d_scan_gap%0d", round, s),
                                start_cyc[acc] - sd_cyc[s], SD, SD + 3);
            end
            check($sformatf("rnd%0d_single_start", round), dbl_start, 0);
        end

        // Enable dropped during channel 1: scan completes, then idles.
        do_reset();
        fixed_en = 1;
        fixed_data = 16'hA55A;
        channel_mask = 4'b1111;
        enable = 1'b1;
        wait_txn("endrop_ch1", 4, 2000);
        enable = 1'b0;
        wait_scan_done("endrop", 1, 2000);
        repeat (SD + 10) @(negedge clk);
        check("endrop_nsamp", samp_ch.size(), 4);
        check("endrop_txn_count", txn_log.size(), 12);
        check("endrop_scan_done_cnt", sd_cnt, 1);
        enable = 1'b1;
        channel_mask = 4'b0010;
        repeat (5) @(negedge clk);
        check("endrop_restart_txn", txn_log.size(), 13);
        if (txn_log.size() >= 13) check("endrop_restart_ch1", txn_log[12].b1, 8'hD3);
        enable = 1'b0;
        repeat (SD + 200) @(negedge clk);

        // Reset during the read of channel 0: immediate abort, no sample.
        do_reset();
        fixed_en = 1;
        fixed_data = 16'h1357;
        channel_mask = 4'b1111;
        enable = 1'b1;
        wait_txn("rstrd_read", 3, 2000);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstrd_start", i2c.i2c_transaction_start, 0);
        check("rstrd_rd_nwr", i2c.i2c_transaction_rd_nwr, 0);
        check("rstrd_bytes", 32'(i2c.i2c_transaction_bytes_num), 0);
        check("rstrd_sample_valid", sample_valid, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_txn("rstrd_restart", 4, 200);
        check("rstrd_no_sample", samp_ch.size(), 0);
        check("rstrd_chdata0", channel_data[0], 16'h0);
        if (txn_log.size() >= 4) begin
            check("rstrd_restart_rd", txn_log[3].rd, 0);
            check("rstrd_restart_cfg", txn_log[3].b1, 8'hC3);
        end
        enable = 1'b0;
        wait_scan_done("rstrd_finish", 1, 2000);
        repeat (SD + 20) @(negedge clk);

`ifdef ADC_TIMEOUT_EN
        // Done withheld for the channel-1 config write.
        do_reset();
        fixed_en = 1;
        fixed_data = 16'h5A5A;
        hold_en = 1;
        hold_cfg = 8'hD3;
        channel_mask = 4'b1111;
        enable = 1'b1;
        wait_scan_done("tmo", 1, 3000);
        enable = 1'b0;
        hold_en = 0;
        repeat (SD + 20) @(negedge clk);
        check("tmo_err", timeout_err, 1);
        check("tmo_txn_count", txn_log.size(), 10);
        check("tmo_nsamp", samp_ch.size(), 3);
        if (samp_ch.size() == 3) begin
            check("tmo_samp0_ch", samp_ch[0], 0);
            check("tmo_samp1_ch", samp_ch[1], 2);
            check("tmo_samp2_ch", samp_ch[2], 3);
        end
        check("tmo_chdata1", channel_data[1], 16'h0);
        check("tmo_chdata2", channel_data[2], 16'h5A5A);
        do_reset();
        check("tmo_err_cleared", timeout_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
